// File: rtl/ex_stage_pkg.sv
// Shared pipeline definitions: ID/EX bundle layout, ALU opcodes, R-type funct codes.
// Latency: n/a (constants, types and constant functions only).
// Backpressure: n/a.
//
// The ID/EX writer and the EX stage both take field positions from here.
// Control bits and PC sit at fixed offsets. The operand fields scale with
// OPW, so every position above them comes from the helper functions.
package ex_stage_pkg;

  // Fixed-position control bits (LSB first).
  localparam int REGDST_BIT   = 0;
  localparam int BRANCH_BIT   = 1;
  localparam int MEMREAD_BIT  = 2;
  localparam int MEMTOREG_BIT = 3;
  localparam int ALUOP_LSB    = 4;
  localparam int ALUOP_W      = 2;
  localparam int MEMWRITE_BIT = 6;
  localparam int ALUSRC_BIT   = 7;
  localparam int REGWRITE_BIT = 8;

  // Wide fields.
  localparam int PC_LSB  = 9;
  localparam int PC_W    = 32;
  localparam int RS_LSB  = PC_LSB + PC_W;
  localparam int IMM_W   = 32;
  localparam int REG_AW  = 5;
  localparam int DATA_W  = 32;
  localparam int FUNCT_W = 6;

  // Offsets of the fields that sit above the OPW-wide operands.
  function automatic int rt_lsb(input int opw);
    return RS_LSB + opw;
  endfunction

  function automatic int imm_lsb(input int opw);
    return RS_LSB + 2 * opw;
  endfunction

  function automatic int rt_addr_lsb(input int opw);
    return imm_lsb(opw) + IMM_W;
  endfunction

  function automatic int rd_addr_lsb(input int opw);
    return rt_addr_lsb(opw) + REG_AW;
  endfunction

  function automatic int id_ex_width(input int opw);
    return rd_addr_lsb(opw) + REG_AW;
  endfunction

  // ALUop field encodings.
  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_UNDEF = 2'b11
  } alu_op_e;

  // R-type funct codes, taken from imm[5:0].
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;

  // Control bits carried forward into the EX/MEM slot.
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memread;
    logic memwrite;
    logic branch;
  } ex_ctrl_t;

endpackage

// File: rtl/ex_stage_alu.sv
// 32-bit ALU for the EX stage: add/sub, R-type add/sub/and/or/slt.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result follows a, b and the opcode directly.
//
// Ports:
//   a, b       32-bit operands
//   ALUop      2-bit operation class
//   funct      R-type function code, used only when ALUop selects R-type
//   result     ALU output; 0 whenever the operation is undefined
//   undefined  high for ALUop 11 or an unknown R-type funct
module alu32
  import ex_stage_pkg::*;
(
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [ALUOP_W-1:0] ALUop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [DATA_W-1:0]  result,
  output logic               undefined
);

  alu_op_e op;

  // All four encodings are enumerated, so the cast cannot leave the enum.
  assign op = alu_op_e'(ALUop);

  always_comb begin
    result    = '0;
    undefined = 1'b0;
    case (op)
      ALUOP_ADD: result = a + b;
      ALUOP_SUB: result = a - b;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: result = a + b;
          FUNCT_SUB: result = a - b;
          FUNCT_AND: result = a & b;
          FUNCT_OR:  result = a | b;
          FUNCT_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
          default:   undefined = 1'b1;
        endcase
      end
      ALUOP_UNDEF: undefined = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: decodes the ID/EX bundle, runs the ALU and registers the EX/MEM slot.
// Latency: one cycle; inputs sampled at edge N appear on the outputs after edge N.
// Backpressure: stall holds the whole slot; flush (which has priority) loads a bubble.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   id_ex_in          packed ID/EX bundle (layout in ex_stage_pkg)
//   in_valid          bundle holds a real instruction this cycle
//   stall, flush      hold / bubble the EX/MEM slot
//   ex_valid          EX/MEM slot holds a real instruction
//   ex_regwrite .. ex_branch  registered control bits (0 for bubbles)
//   ex_alu_result, ex_zero    registered ALU result and its zero flag
//   ex_store_data     rt_data zero-extended
//   ex_branch_target  PC + (imm << 2)
//   ex_take_branch    branch AND zero AND valid, from registered state only
//   ex_write_reg      destination register (rd if RegDst else rt)
//   ex_illegal        sticky flag for a captured valid undefined op
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int OPW = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [id_ex_width(OPW)-1:0]   id_ex_in,
  input  logic                          in_valid,
  input  logic                          stall,
  input  logic                          flush,
  output logic                          ex_valid,
  output logic                          ex_regwrite,
  output logic                          ex_memtoreg,
  output logic                          ex_memread,
  output logic                          ex_memwrite,
  output logic                          ex_branch,
  output logic [DATA_W-1:0]             ex_alu_result,
  output logic                          ex_zero,
  output logic [DATA_W-1:0]             ex_store_data,
  output logic [DATA_W-1:0]             ex_branch_target,
  output logic                          ex_take_branch,
  output logic [REG_AW-1:0]             ex_write_reg,
  output logic                          ex_illegal
);

  localparam int RT_LSB      = rt_lsb(OPW);
  localparam int IMM_LSB     = imm_lsb(OPW);
  localparam int RT_ADDR_LSB = rt_addr_lsb(OPW);
  localparam int RD_ADDR_LSB = rd_addr_lsb(OPW);

  // ---------------------------------------------------------------------
  // Bundle decode
  // ---------------------------------------------------------------------
  logic                 regdst;
  logic                 alusrc;
  logic [ALUOP_W-1:0]   alu_op;
  logic [PC_W-1:0]      pc;
  logic [OPW-1:0]       rs_data;
  logic [OPW-1:0]       rt_data;
  logic [IMM_W-1:0]     imm;
  logic [REG_AW-1:0]    rt_addr;
  logic [REG_AW-1:0]    rd_addr;
  ex_ctrl_t             ctrl_in;

  assign regdst  = id_ex_in[REGDST_BIT];
  assign alusrc  = id_ex_in[ALUSRC_BIT];
  assign alu_op  = id_ex_in[ALUOP_LSB +: ALUOP_W];
  assign pc      = id_ex_in[PC_LSB +: PC_W];
  assign rs_data = id_ex_in[RS_LSB +: OPW];
  assign rt_data = id_ex_in[RT_LSB +: OPW];
  assign imm     = id_ex_in[IMM_LSB +: IMM_W];
  assign rt_addr = id_ex_in[RT_ADDR_LSB +: REG_AW];
  assign rd_addr = id_ex_in[RD_ADDR_LSB +: REG_AW];

  assign ctrl_in.regwrite = id_ex_in[REGWRITE_BIT];
  assign ctrl_in.memtoreg = id_ex_in[MEMTOREG_BIT];
  assign ctrl_in.memread  = id_ex_in[MEMREAD_BIT];
  assign ctrl_in.memwrite = id_ex_in[MEMWRITE_BIT];
  assign ctrl_in.branch   = id_ex_in[BRANCH_BIT];

  // ---------------------------------------------------------------------
  // Operands and ALU
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] rt_ext;
  logic [DATA_W-1:0] alu_result;
  logic              alu_undefined;

  // Register operands are unsigned fields; the casts zero-extend them.
  assign op_a   = DATA_W'(rs_data);
  assign rt_ext = DATA_W'(rt_data);
  assign op_b   = alusrc ? imm : rt_ext;

  alu32 u_alu (
    .a         (op_a),
    .b         (op_b),
    .ALUop     (alu_op),
    .funct     (imm[FUNCT_W-1:0]),
    .result    (alu_result),
    .undefined (alu_undefined)
  );

  // ---------------------------------------------------------------------
  // Next-slot values for a capture
  // ---------------------------------------------------------------------
  ex_ctrl_t          ctrl_d;
  logic [DATA_W-1:0] target_d;
  logic [REG_AW-1:0] write_reg_d;

  // A non-valid capture still loads data but must not carry side-effecting controls.
  assign ctrl_d      = in_valid ? ctrl_in : '0;
  assign target_d    = pc + (imm << 2);
  assign write_reg_d = regdst ? rd_addr : rt_addr;

  // ---------------------------------------------------------------------
  // EX/MEM slot: reset > flush > stall > capture
  // ---------------------------------------------------------------------
  ex_ctrl_t ctrl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid         <= 1'b0;
      ctrl_q           <= '0;
      ex_alu_result    <= '0;
      ex_zero          <= 1'b0;
      ex_store_data    <= '0;
      ex_branch_target <= '0;
      ex_write_reg     <= '0;
    end else if (flush) begin
      ex_valid         <= 1'b0;
      ctrl_q           <= '0;
      ex_alu_result    <= '0;
      ex_zero          <= 1'b0;
      ex_store_data    <= '0;
      ex_branch_target <= '0;
      ex_write_reg     <= '0;
    end else if (!stall) begin
      ex_valid         <= in_valid;
      ctrl_q           <= ctrl_d;
      ex_alu_result    <= alu_result;
      ex_zero          <= (alu_result == '0);
      ex_store_data    <= rt_ext;
      ex_branch_target <= target_d;
      ex_write_reg     <= write_reg_d;
    end
  end

  // Sticky: only a real capture of a valid undefined op sets it, only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_illegal <= 1'b0;
    end else if (!flush && !stall && in_valid && alu_undefined) begin
      ex_illegal <= 1'b1;
    end
  end

  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_branch   = ctrl_q.branch;

  // Built from registered state only, so it is glitch-free relative to the inputs.
  assign ex_take_branch = ctrl_q.branch & ex_zero & ex_valid;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter OPW, default 8, width of each register-operand field in the ID/EX bundle.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 id_ex_in  input  99  packed ID/EX bundle, LSB first: RegDst[0], Branch[1], MemRead[2], MemtoReg[3], ALUop[5:4], MemWrite[6], ALUsrc[7], RegWrite[8], PC[40:9], rs_data[48:41], rt_data[56:49], imm[88:57], rt_addr[93:89], rd_addr[98:94].
REQ-005 in_valid  input  1  id_ex_in carries a real instruction this cycle.
REQ-006 stall  input  1  hold all EX/MEM outputs.
REQ-007 flush  input  1  replace next EX/MEM contents with a bubble.
REQ-008 ex_valid  output  1  EX/MEM slot holds a real instruction.
REQ-009 ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_branch  output  1 each  registered control bits.
REQ-010 ex_alu_result  output  32  registered ALU result.
REQ-011 ex_zero  output  1  registered (ALU result == 0).
REQ-012 ex_store_data  output  32  rt_data zero-extended to 32 bits.
REQ-013 ex_branch_target  output  32  PC + (imm << 2), modulo 2^32.
REQ-014 ex_take_branch  output  1  ex_branch AND ex_zero AND ex_valid.
REQ-015 ex_write_reg  output  5  rd_addr if RegDst=1, else rt_addr.
REQ-016 ex_illegal  output  1  sticky flag, set on any captured valid instruction with an undefined operation.

Function
REQ-017 Operand A SHALL be rs_data zero-extended to 32 bits; operand B SHALL be imm if ALUsrc=1, else rt_data zero-extended.
REQ-018 ALUop 00 SHALL select add; 01 SHALL select subtract; 11 SHALL be undefined.
REQ-019 ALUop 10 SHALL decode funct=imm[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed set-less-than (result 1 or 0); any other funct SHALL be undefined.
REQ-020 An undefined operation SHALL produce ALU result 0 and SHALL set ex_illegal if in_valid=1 at capture.
REQ-021 All arithmetic SHALL be 32-bit wrap-around, with no overflow trap.
REQ-022 Latency SHALL be one cycle: inputs sampled at rising edge N appear on outputs after edge N.
REQ-023 Priority at each edge SHALL be: flush > stall > capture.
REQ-024 On flush, ex_valid and all five control outputs SHALL be 0, and the data outputs SHALL be 0.
REQ-025 On stall without flush, every output SHALL hold its value, and ex_illegal SHALL NOT be updated.
REQ-026 On capture with in_valid=0, ex_valid and the controls SHALL be 0, and the data outputs SHALL still load their computed values.
REQ-027 On capture with in_valid=1, ex_valid=1 and the controls SHALL copy their bundle bits.
REQ-028 ex_take_branch SHALL be combinational from registered state only.
REQ-029 ex_illegal SHALL clear only on reset.

Reset
REQ-030 While rst_n=0, all outputs SHALL be 0 immediately, independent of clk.
REQ-031 Reset asserted mid-stall or mid-flush SHALL take priority.
REQ-032 The first edge after reset release SHALL behave as a normal capture.

Structure
REQ-033 Bundle bit offsets, ALUop encodings and funct codes SHALL be constants in the shared pipeline package, so the ID/EX writer and this block use one definition.
REQ-034 The ALU SHALL be a separate combinational sub-module, alu32, with inputs a, b, ALUop, funct and outputs result, undefined; ex_stage SHALL own all state.

Verification
REQ-035 Reset: rst_n=0 asynchronously mid-cycle -> all outputs read 0 before the next edge.
REQ-036 R-type sub: rs_data=0x05, rt_data=0x05, ALUop=10, imm=0x22, RegDst=1, rd_addr=7, in_valid=1 -> after one edge: ex_alu_result=0, ex_zero=1, ex_write_reg=7, ex_valid=1.
REQ-037 Branch: Branch=1, ALUop=01, rs_data=rt_data=0x10, PC=0x100, imm=0xFFFFFFFF -> ex_branch_target=0x000000FC, ex_take_branch=1.
REQ-038 Immediate/slt: ALUsrc=1, ALUop=10, funct 0x2A, rs_data=0x01, imm=0x0000002A -> ex_alu_result=1; the same with ALUop=00 -> 0x2B.
REQ-039 Stall then flush: capture a valid add; assert stall for 3 cycles -> outputs unchanged; then assert flush together with stall -> ex_valid=0 and controls 0.
REQ-040 Illegal: ALUop=11, in_valid=1 -> ex_alu_result=0 and ex_illegal=1, staying 1 through later legal ops until rst_n=0.
